issue_ctrl: RTL and testbench

ISSUE_CTRL -- requirements
Module: issue_ctrl

---
 rtl/issue_ctrl_pkg.sv | 41 ++++
 rtl/issue_ctrl_if.sv | 29 ++
 rtl/issue_ctrl_classify.sv | 20 ++
 rtl/issue_ctrl.sv | 90 +++++++++
 tb/tb_issue_ctrl.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/issue_ctrl_pkg.sv
// rtl/issue_ctrl_pkg.sv - shared opcodes, state and class types for issue_ctrl
package issue_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        CLS_DROP = 2'd0,
        CLS_RS   = 2'd1,
        CLS_LSB  = 2'd2
    } op_class_t;

    localparam int OP_NONE  = 0;
    localparam int OP_LUI   = 1;
    localparam int OP_AUIPC = 2;
    localparam int OP_JAL   = 3;
    localparam int OP_JALR  = 4;
    localparam int OP_BEQ   = 5;
    localparam int OP_BGEU  = 10;
    localparam int OP_LB    = 11;
    localparam int OP_LH    = 12;
    localparam int OP_LW    = 13;
    localparam int OP_LBU   = 14;
    localparam int OP_LHU   = 15;
    localparam int OP_SB    = 16;
    localparam int OP_SH    = 17;
    localparam int OP_SW    = 18;
    localparam int OP_ADDI  = 19;
    localparam int OP_ANDI  = 23;
    localparam int OP_ADD   = 28;
    localparam int OP_SUB   = 29;
    localparam int OP_AND   = 37;

    // Loads and stores occupy one contiguous opcode range.
    localparam int OP_LS_LO = OP_LB;
    localparam int OP_LS_HI = OP_SW;

endpackage

// File: rtl/issue_ctrl_if.sv
// rtl/issue_ctrl_if.sv - queue-head, downstream-flag and issue-bundle signals
interface issue_ctrl_if #(
    parameter int TAG_W = 4,
    parameter int OP_W  = 6
);
    logic             rdy;
    logic             flush;
    logic             iq_empty;
    logic [OP_W-1:0]  dc_op;
    logic             rob_full;
    logic             rs_full;
    logic             lsb_full;
    logic             iq_pop;
    logic             issue_valid;
    logic [OP_W-1:0]  issue_op;
    logic             issue_to_lsb;
    logic [TAG_W-1:0] issue_tag;
    logic [31:0]      stall_cnt;

    modport master (
        output rdy, flush, iq_empty, dc_op, rob_full, rs_full, lsb_full,
        input  iq_pop, issue_valid, issue_op, issue_to_lsb, issue_tag, stall_cnt
    );

    modport slave (
        input  rdy, flush, iq_empty, dc_op, rob_full, rs_full, lsb_full,
        output iq_pop, issue_valid, issue_op, issue_to_lsb, issue_tag, stall_cnt
    );
endinterface

// File: rtl/issue_ctrl_classify.sv
// rtl/issue_ctrl_classify.sv - combinational opcode to LSB/RS/drop class
module issue_classify
    import issue_ctrl_pkg::*;
#(
    parameter int OP_W = 6
) (
    input  logic [OP_W-1:0] op,
    output op_class_t       cls
);
    localparam logic [OP_W-1:0] LS_LO = OP_W'(OP_LS_LO);
    localparam logic [OP_W-1:0] LS_HI = OP_W'(OP_LS_HI);

    always_comb begin
        cls = CLS_RS;
        if (op == '0)
            cls = CLS_DROP;
        else if (op >= LS_LO && op <= LS_HI)
            cls = CLS_LSB;
    end
endmodule

// File: rtl/issue_ctrl.sv
// rtl/issue_ctrl.sv - in-order issue stage: pops the decoded queue head, assigns ROB tags
module issue_ctrl
    import issue_ctrl_pkg::*;
#(
    parameter int TAG_W = 4,
    parameter int OP_W  = 6
) (
    input  logic         clk,
    input  logic         rst,
    issue_ctrl_if.slave  bus
);
    state_t           state, state_nxt;
    op_class_t        cls;
    logic [TAG_W-1:0] tag;
    logic             target_full;
    logic             can_try;
    logic             accept;
    logic             issue_valid_q;
    logic [OP_W-1:0]  issue_op_q;
    logic             issue_to_lsb_q;
    logic [TAG_W-1:0] issue_tag_q;
    logic [31:0]      stall_cnt_q;

    issue_classify #(.OP_W(OP_W)) u_classify (
        .op  (bus.dc_op),
        .cls (cls)
    );

    always_comb begin
        target_full = (cls == CLS_LSB) ? bus.lsb_full : bus.rs_full;
        can_try     = bus.rdy & ~bus.flush & ~bus.iq_empty & (state != ST_FLUSH);
        // Unrecognised ops never occupy a downstream slot, so they are dropped regardless of fullness.
        accept      = can_try & ((cls == CLS_DROP) | (~bus.rob_full & ~target_full));
    end

    assign bus.iq_pop = accept & ~rst;

    always_comb begin
        state_nxt = state;
        if (bus.rdy) begin
            if (bus.flush) begin
                state_nxt = ST_FLUSH;
            end else begin
                case (state)
                    ST_RUN:   if (can_try && !accept) state_nxt = ST_STALL;
                    ST_STALL: if (accept) state_nxt = ST_RUN;
                    ST_FLUSH: state_nxt = ST_RUN;
                    default:  state_nxt = ST_RUN;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= ST_RUN;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag            <= '0;
            issue_valid_q  <= 1'b0;
            issue_op_q     <= '0;
            issue_to_lsb_q <= 1'b0;
            issue_tag_q    <= '0;
            stall_cnt_q    <= '0;
        end else if (bus.rdy) begin
            issue_valid_q <= accept && (cls != CLS_DROP);
            if (accept && cls != CLS_DROP) begin
                issue_op_q     <= bus.dc_op;
                issue_to_lsb_q <= (cls == CLS_LSB);
                issue_tag_q    <= tag;
            end
            if (bus.flush)
                tag <= '0;
            else if (accept && cls != CLS_DROP)
                tag <= tag + TAG_W'(1);
            if (state == ST_STALL && stall_cnt_q != 32'hFFFF_FFFF)
                stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign bus.issue_valid  = issue_valid_q;
    assign bus.issue_op     = issue_op_q;
    assign bus.issue_to_lsb = issue_to_lsb_q;
    assign bus.issue_tag    = issue_tag_q;
    assign bus.stall_cnt    = stall_cnt_q;
endmodule

// File: tb/tb_issue_ctrl.sv
// tb/tb_issue_ctrl.sv - directed and randomized checks of issue_ctrl against a reference model
module tb_issue_ctrl;
    import issue_ctrl_pkg::*;

    localparam int TAG_W = 4;
    localparam int OP_W  = 6;
    localparam int DEPTH = 1 << TAG_W;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    issue_ctrl_if #(.TAG_W(TAG_W), .OP_W(OP_W)) bus ();

    issue_ctrl #(.TAG_W(TAG_W), .OP_W(OP_W)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: 0 = running, 1 = stalled, 2 = flushing.
    int          m_mode;
    int          m_tag;
    logic [31:0] m_cnt;
    logic        m_valid;
    int          m_op;
    logic        m_lsb;
    int          m_itag;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode  = 0;
        m_tag   = 0;
        m_cnt   = 32'd0;
        m_valid = 1'b0;
        m_op    = 0;
        m_lsb   = 1'b0;
        m_itag  = 0;
    endtask

    // Called at a negedge; drives one cycle, checks iq_pop before the edge and registers after it.
    task automatic cycle(input logic r, input logic fl, input logic emp, input int op,
                         input logic robf, input logic rsf, input logic lsbf);
        bit is_ls, blocked, pop;
        bus.rdy      = r;
        bus.flush    = fl;
        bus.iq_empty = emp;
        bus.dc_op    = OP_W'(op);
        bus.rob_full = robf;
        bus.rs_full  = rsf;
        bus.lsb_full = lsbf;
        is_ls   = (op >= OP_LS_LO) && (op <= OP_LS_HI);
        blocked = (op != 0) && (robf || (is_ls ? lsbf : rsf));
        pop     = r && !fl && !emp && (m_mode != 2) && !blocked;
        #1;
        check_eq("iq_pop", {31'd0, bus.iq_pop}, {31'd0, pop});
        @(posedge clk);
        if (r) begin
            if (m_mode == 1 && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
            m_valid = pop && (op != 0);
            if (m_valid) begin
                m_op   = op;
                m_lsb  = is_ls;
                m_itag = m_tag;
                m_tag  = (m_tag + 1) % DEPTH;
            end
            if (fl) begin
                m_tag  = 0;
                m_mode = 2;
            end else if (m_mode == 2) begin
                m_mode = 0;
            end else if (m_mode == 0 && !emp && blocked) begin
                m_mode = 1;
            end else if (m_mode == 1 && pop) begin
                m_mode = 0;
            end
        end
        #1;
        check_eq("issue_valid", {31'd0, bus.issue_valid}, {31'd0, m_valid});
        check_eq("stall_cnt", bus.stall_cnt, m_cnt);
        if (m_valid) begin
            check_eq("issue_op", 32'(bus.issue_op), 32'(m_op));
            check_eq("issue_to_lsb", {31'd0, bus.issue_to_lsb}, {31'd0, m_lsb});
            check_eq("issue_tag", 32'(bus.issue_tag), 32'(m_itag));
        end
        @(negedge clk);
    endtask

    task automatic check_cleared(input string tag);
        check_eq({tag, "_valid"}, {31'd0, bus.issue_valid}, 32'd0);
        check_eq({tag, "_op"}, 32'(bus.issue_op), 32'd0);
        check_eq({tag, "_lsb"}, {31'd0, bus.issue_to_lsb}, 32'd0);
        check_eq({tag, "_tag"}, 32'(bus.issue_tag), 32'd0);
        check_eq({tag, "_cnt"}, bus.stall_cnt, 32'd0);
        check_eq({tag, "_pop"}, {31'd0, bus.iq_pop}, 32'd0);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        model_reset();
        rst          = 1'b1;
        bus.rdy      = 1'b1;
        bus.flush    = 1'b0;
        bus.iq_empty = 1'b0;
        bus.dc_op    = OP_W'(OP_ADDI);
        bus.rob_full = 1'b0;
        bus.rs_full  = 1'b0;
        bus.lsb_full = 1'b0;
        #2;
        check_cleared("reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Three back-to-back ADDI.
        for (int i = 0; i < 3; i++) begin
            cycle(1, 0, 0, OP_ADDI, 0, 0, 0);
            check_eq("addi_tag", 32'(bus.issue_tag), 32'(i));
        end

        // LW held off by a full LSB for four cycles.
        for (int i = 0; i < 4; i++) cycle(1, 0, 0, OP_LW, 0, 0, 1);
        cycle(1, 0, 0, OP_LW, 0, 0, 0);
        check_eq("lw_stall_cnt", bus.stall_cnt, 32'd4);
        check_eq("lw_to_lsb", {31'd0, bus.issue_to_lsb}, 32'd1);

        // Seventeen issues from tag 0 wrap 15 -> 0.
        cycle(1, 1, 0, OP_ADD, 0, 0, 0);
        cycle(1, 0, 1, OP_ADD, 0, 0, 0);
        for (int i = 0; i < 17; i++) begin
            cycle(1, 0, 0, (i % 2) ? OP_SW : OP_ADD, 0, 0, 0);
            check_eq("wrap_tag", 32'(bus.issue_tag), 32'(i % DEPTH));
        end

        // Flush coincident with a ready ADD at tag 5.
        cycle(1, 1, 0, OP_ADD, 0, 0, 0);
        cycle(1, 0, 1, OP_ADD, 0, 0, 0);
        for (int i = 0; i < 5; i++) cycle(1, 0, 0, OP_ADD, 0, 0, 0);
        cycle(1, 1, 0, OP_ADD, 0, 0, 0);
        check_eq("flush_valid", {31'd0, bus.issue_valid}, 32'd0);
        cycle(1, 0, 0, OP_ADD, 0, 0, 0);
        cycle(1, 0, 0, OP_ADD, 0, 0, 0);
        check_eq("post_flush_tag", 32'(bus.issue_tag), 32'd0);

        // Unrecognised op dropped, then rdy low freezes everything.
        cycle(1, 0, 0, OP_NONE, 0, 0, 0);
        cycle(1, 0, 0, OP_NONE, 1, 1, 1);
        cycle(1, 0, 0, OP_ADDI, 0, 0, 0);
        check_eq("after_drop_tag", 32'(bus.issue_tag), 32'd1);
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, OP_ADD, 0, 0, 0);
        cycle(0, 1, 0, OP_LW, 0, 0, 0);

        // Asynchronous reset while stalled.
        for (int i = 0; i < 3; i++) cycle(1, 0, 0, OP_LW, 0, 0, 1);
        bus.lsb_full = 1'b0;
        bus.dc_op    = OP_W'(OP_LW);
        bus.rdy      = 1'b1;
        bus.flush    = 1'b0;
        bus.iq_empty = 1'b0;
        #2 rst = 1'b1;
        #1;
        check_cleared("async_rst");
        model_reset();
        @(negedge clk);
        rst = 1'b0;

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            int op;
            op = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 40));
            cycle($urandom_range(0, 9) != 0,
                  $urandom_range(0, 19) == 0,
                  $urandom_range(0, 4) == 0,
                  op,
                  $urandom_range(0, 3) == 0,
                  $urandom_range(0, 3) == 0,
                  $urandom_range(0, 3) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
